// File: rtl/counter32_timer_arbiter.sv
// Round-robin arbiter sharing one 32-bit preset/down-count timer cell.
// Grants one requester at a time, loads its delay, counts to zero, pulses done.
module counter32_timer_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic [NUM_REQ-1:0]      Req_i,
    input  logic [32*NUM_REQ-1:0]   Delay_i,
    output logic [NUM_REQ-1:0]      Grant_o,
    output logic [NUM_REQ-1:0]      Done_o,
    output logic                    Busy_o,
    output logic                    Timer_Preset_o,
    output logic                    Timer_Enable_o,
    output logic [31:0]             Timer_PresetVal_o,
    input  logic                    Timer_Zero_i
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        own_q;
    logic [IW-1:0]        own_nxt;
    logic [IW-1:0]        win;
    logic [IW-1:0]        cand;
    logic                 found;
    int                   idx;
    logic [31:0]          delay_sel;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 abort;

    // Search starts at the pointer and wraps, so the last owner goes last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IW'(idx);
            if (!found && Req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        delay_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IW'(k)) begin
                delay_sel = Delay_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    assign own_nxt = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
    assign abort   = !Req_i[own_q];

    // Dropping enable on zero in the same cycle keeps the timer from wrapping.
    assign Timer_Enable_o = (state_q == RUN) && !Timer_Zero_i;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q           <= IDLE;
            ptr_q             <= '0;
            own_q             <= '0;
            Grant_o           <= '0;
            Done_o            <= '0;
            Busy_o            <= 1'b0;
            Timer_Preset_o    <= 1'b0;
            Timer_PresetVal_o <= '0;
        end else begin
            Timer_Preset_o <= 1'b0;
            Done_o         <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        own_q             <= win;
                        Grant_o           <= win_oh;
                        Timer_PresetVal_o <= delay_sel;
                        Timer_Preset_o    <= 1'b1;
                        Busy_o            <= 1'b1;
                        state_q           <= LOAD;
                    end
                end
                LOAD, RUN: begin
                    // Abort outranks a same-cycle zero: no done pulse.
                    if (abort) begin
                        state_q <= IDLE;
                        Grant_o <= '0;
                        Busy_o  <= 1'b0;
                        ptr_q   <= own_nxt;
                    end else if (state_q == LOAD) begin
                        state_q <= RUN;
                    end else if (Timer_Zero_i) begin
                        Done_o  <= Grant_o;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    Grant_o <= '0;
                    Busy_o  <= 1'b0;
                    ptr_q   <= own_nxt;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter32_timer_arbiter.sv
// Directed bench for counter32_timer_arbiter with a behavioural timer cell.
// Expected values are hand-derived from the edge timing of each scenario.
module tb_counter32_timer_arbiter;

    logic         Clk_i = 1'b0;
    logic         Reset_i = 1'b1;
    logic [3:0]   Req_i = '0;
    logic [127:0] Delay_i = '0;
    logic [3:0]   Grant_o;
    logic [3:0]   Done_o;
    logic         Busy_o;
    logic         Timer_Preset_o;
    logic         Timer_Enable_o;
    logic [31:0]  Timer_PresetVal_o;
    logic         Timer_Zero_i;

    logic [31:0]  tcnt = '0;

    int n_chk = 0;
    int n_pass = 0;

    counter32_timer_arbiter #(.NUM_REQ(4)) dut (
        .Clk_i             (Clk_i),
        .Reset_i           (Reset_i),
        .Req_i             (Req_i),
        .Delay_i           (Delay_i),
        .Grant_o           (Grant_o),
        .Done_o            (Done_o),
        .Busy_o            (Busy_o),
        .Timer_Preset_o    (Timer_Preset_o),
        .Timer_Enable_o    (Timer_Enable_o),
        .Timer_PresetVal_o (Timer_PresetVal_o),
        .Timer_Zero_i      (Timer_Zero_i)
    );

    always #5 Clk_i = ~Clk_i;

    // Timer cell: preset wins over enable, zero flag is combinational.
    always @(posedge Clk_i) begin
        if (Timer_Preset_o) tcnt <= Timer_PresetVal_o;
        else if (Timer_Enable_o) tcnt <= tcnt - 32'd1;
    end
    assign Timer_Zero_i = (tcnt == 32'd0);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic set_delay(input int k, input logic [31:0] d);
        Delay_i[32*k +: 32] = d;
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh == (4'b1 << i)) return i;
        return -1;
    endfunction

    task automatic check_idle(input string p);
        chk({p, "_grant"}, 32'(Grant_o), 32'h0);
        chk({p, "_done"}, 32'(Done_o), 32'h0);
        chk({p, "_busy"}, 32'(Busy_o), 32'h0);
        chk({p, "_preset"}, 32'(Timer_Preset_o), 32'h0);
        chk({p, "_enable"}, 32'(Timer_Enable_o), 32'h0);
        chk({p, "_pval"}, Timer_PresetVal_o, 32'h0);
    endtask

    // Samples after edges E1..E(lim); requester drops its request on done.
    task automatic run_to_done(input int lim, output int en_n, output int pre_n,
                               output int done_e, output logic [3:0] done_v,
                               output int done_n, output logic [3:0] g_after);
        en_n = 0; pre_n = 0; done_e = 0; done_v = '0; done_n = 0;
        g_after = 4'hF;
        for (int e = 1; e <= lim; e++) begin
            tick();
            if (Timer_Enable_o) en_n++;
            if (Timer_Preset_o) pre_n++;
            if (done_n > 0 && e == done_e + 1) g_after = Grant_o;
            if (Done_o != 0) begin
                done_n++;
                done_e = e;
                done_v = Done_o;
                Req_i  = Req_i & ~Done_o;
            end
        end
    endtask

    int         en_n, pre_n, done_e, done_n;
    logic [3:0] done_v, g_after;
    int         gidx[5];
    int         gtime[5];
    int         ng;
    logic [3:0] prev_g, reraise;
    bit         saw_done1;

    initial begin
        // Reset state
        tick();
        tick();
        check_idle("reset");
        Reset_i = 1'b0;

        // Single request, D=5
        set_delay(0, 32'd5);
        Req_i = 4'b0001;
        tick();
        chk("t1_grant_e0", 32'(Grant_o), 32'h1);
        chk("t1_busy_e0", 32'(Busy_o), 32'h1);
        chk("t1_pval_e0", Timer_PresetVal_o, 32'd5);
        chk("t1_preset_e0", 32'(Timer_Preset_o), 32'h1);
        run_to_done(12, en_n, pre_n, done_e, done_v, done_n, g_after);
        chk("t1_enable_cycles", 32'(en_n), 32'd5);
        chk("t1_preset_extra", 32'(pre_n), 32'd0);
        chk("t1_done_edge", 32'(done_e), 32'd7);
        chk("t1_done_val", 32'(done_v), 32'h1);
        chk("t1_done_count", 32'(done_n), 32'd1);
        chk("t1_grant_e8", 32'(g_after), 32'h0);
        chk("t1_busy_after", 32'(Busy_o), 32'h0);

        // D=0 on requester 2
        set_delay(2, 32'd0);
        Req_i = 4'b0100;
        tick();
        chk("t2_grant_e0", 32'(Grant_o), 32'h4);
        run_to_done(8, en_n, pre_n, done_e, done_v, done_n, g_after);
        chk("t2_enable_cycles", 32'(en_n), 32'd0);
        chk("t2_done_edge", 32'(done_e), 32'd2);
        chk("t2_done_val", 32'(done_v), 32'h4);

        // Round-robin with all four requesting, D=3 each
        Reset_i = 1'b1;
        tick();
        Reset_i = 1'b0;
        for (int k = 0; k < 4; k++) set_delay(k, 32'd3);
        Req_i   = 4'b1111;
        ng      = 0;
        prev_g  = '0;
        reraise = '0;
        for (int t = 0; t < 60 && ng < 5; t++) begin
            tick();
            Req_i   = Req_i | reraise;
            reraise = Done_o;
            Req_i   = Req_i & ~Done_o;
            if (Grant_o != 0 && prev_g == 0) begin
                gidx[ng]  = oh2idx(Grant_o);
                gtime[ng] = t;
                ng++;
            end
            prev_g = Grant_o;
        end
        chk("t3_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_order%0d", i), 32'(gidx[i]), 32'(i % 4));
            if (i > 0)
                chk($sformatf("t3_gap%0d", i), 32'(gtime[i] - gtime[i-1]), 32'd7);
        end
        Req_i = '0;
        for (int t = 0; t < 6; t++) tick();
        chk("t3_idle_after", 32'(Busy_o), 32'h0);

        // Abort of requester 1 at RUN cycle 10 with requester 2 pending
        set_delay(1, 32'd100);
        set_delay(2, 32'd4);
        Req_i = 4'b0110;
        saw_done1 = 1'b0;
        tick();
        chk("t4_grant_e0", 32'(Grant_o), 32'h2);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (Done_o[1]) saw_done1 = 1'b1;
        end
        chk("t4_enable_run10", 32'(Timer_Enable_o), 32'h1);
        Req_i = 4'b0100;
        tick();
        if (Done_o[1]) saw_done1 = 1'b1;
        chk("t4_grant_abort", 32'(Grant_o), 32'h0);
        chk("t4_busy_abort", 32'(Busy_o), 32'h0);
        chk("t4_enable_abort", 32'(Timer_Enable_o), 32'h0);
        chk("t4_residual", tcnt, 32'd90);
        tick();
        chk("t4_grant2", 32'(Grant_o), 32'h4);
        chk("t4_pval2", Timer_PresetVal_o, 32'd4);
        tick();
        chk("t4_fresh_load", tcnt, 32'd4);
        chk("t4_enable2", 32'(Timer_Enable_o), 32'h1);
        en_n = 1;
        done_e = 0;
        done_v = '0;
        for (int e = 2; e <= 10; e++) begin
            tick();
            if (Timer_Enable_o) en_n++;
            if (Done_o[1]) saw_done1 = 1'b1;
            if (Done_o != 0) begin
                done_e = e;
                done_v = Done_o;
                Req_i  = Req_i & ~Done_o;
            end
        end
        chk("t4_enable_cycles2", 32'(en_n), 32'd4);
        chk("t4_done_edge2", 32'(done_e), 32'd6);
        chk("t4_done_val2", 32'(done_v), 32'h4);
        chk("t4_no_done1", 32'(saw_done1), 32'h0);

        // Reset pulsed mid-RUN with D=50
        set_delay(0, 32'd50);
        Req_i = 4'b0001;
        tick();
        chk("t5_grant_e0", 32'(Grant_o), 32'h1);
        for (int t = 0; t < 10; t++) tick();
        chk("t5_enable_run", 32'(Timer_Enable_o), 32'h1);
        Reset_i = 1'b1;
        tick();
        check_idle("t5_reset");
        Reset_i = 1'b0;
        Req_i   = 4'b1010;
        tick();
        chk("t5_grant_p0", 32'(Grant_o), 32'h2);
        Req_i = '0;
        for (int t = 0; t < 4; t++) tick();
        chk("t5_idle_end", 32'(Busy_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter32_timer_arbiter.md
# counter32_timer_arbiter

Shares a single 32-bit preset/down-count timer cell among `NUM_REQ` requesters on the WSN SoC. It arbitrates pending delay requests round-robin, loads the winner's delay into the timer, and enables counting until the timer reports zero. It then returns a one-cycle done pulse to that requester. It sits between the requesting sequencers and the timer, and owns the timer's `Preset_i`, `Enable_i` and `PresetVal_i` inputs.

## Interface

- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `Clk_i`  in  1: single clock; all logic is rising-edge.
- `Reset_i`  in  1: synchronous, active-high reset.
- `Req_i`  in  `NUM_REQ`: per-requester level request; held high until Done or abort.
- `Delay_i`  in  `32*NUM_REQ`: requester k's delay is `Delay_i[32k+31:32k]`; must be stable on the grant edge.
- `Grant_o`  out  `NUM_REQ`: one-hot; marks the requester currently owning the timer.
- `Done_o`  out  `NUM_REQ`: one-hot, one-cycle pulse; marks the delay as expired.
- `Busy_o`  out  1: high whenever the state is not IDLE.
- `Timer_Preset_o`  out  1: drives the timer's preset input.
- `Timer_Enable_o`  out  1: drives the timer's count enable.
- `Timer_PresetVal_o`  out  32: drives the timer's preset value.
- `Timer_Zero_i`  in  1: the timer's zero flag, combinational on the count value.

## Operation

- **States:** IDLE, LOAD, RUN, DONE. All outputs are registered, except that `Timer_Enable_o` may be decoded from state and `Timer_Zero_i`.
- **IDLE:** if any `Req_i` bit is high, select winner k round-robin, starting the search at pointer P. Then:
  - capture `Delay_i[k]` into `Timer_PresetVal_o`;
  - set `Grant_o` to one-hot k;
  - go to LOAD.
- **LOAD:** `Timer_Preset_o`=1 for exactly this one cycle; go to RUN.
- **RUN:** `Timer_Enable_o`=1 while `Timer_Zero_i`=0. When `Timer_Zero_i`=1, `Timer_Enable_o`=0 in that same cycle, so the timer never wraps; go to DONE.
- **DONE:** `Done_o[k]`=1 for this one cycle; `Grant_o` is still k. Next edge: go to IDLE, clear `Grant_o`, set P = (k+1) mod `NUM_REQ`.
- **Abort:** `Req_i[k]`=0 while in LOAD or RUN.
  - Next edge: go to IDLE, clear `Grant_o`, no Done pulse, set P = (k+1) mod `NUM_REQ`.
  - `Timer_Enable_o` and `Timer_Preset_o` are 0 from that edge on; the timer keeps its residual value.
- **Abort vs Zero:** abort has priority over `Timer_Zero_i` in the same RUN cycle.
- **Request changes:** requests from non-granted requesters are ignored until IDLE. `Delay_i` changes after the grant edge have no effect.
- **Requester handshake:** a requester must drop `Req_i` in the cycle after `Done_o`. If it does not, it is treated as a new request, but only after the other pending requesters, because of the pointer update.
- **Delay 0:** legal. The timer reads zero in the first RUN cycle, and Done follows.
- **Delay 0xFFFFFFFF:** legal. No internal counters overflow.
- **Reset:** on the edge `Reset_i`=1:
  - state IDLE and P=0;
  - `Grant_o`, `Done_o`, `Busy_o`, `Timer_Preset_o`, `Timer_Enable_o` all 0;
  - `Timer_PresetVal_o` = 0.
  - This applies from any state, mid-operation included. Reset dominates every other input.

## Timing

- Let E0 be the edge that samples `Req_i[k]`=1 in IDLE with k winning. Delay is D.
- E0: `Grant_o`, `Busy_o` and `Timer_PresetVal_o` become valid.
- Cycle after E0: `Timer_Preset_o`=1. The timer loads D at E1.
- E1..E(D+1): `Timer_Enable_o`=1 for D cycles. The timer reaches 0 after E(D+1).
- E(D+2): enter DONE; `Done_o[k]`=1 for one cycle.
- E(D+3): `Grant_o` and `Busy_o` are 0.
- Next grant: a new grant can occur at E(D+4) at the earliest, since IDLE samples `Req_i` one cycle after DONE.
- Request-to-done latency is D+2 edges; total occupancy is D+3 cycles.
- Abort sampled at edge Ea: `Grant_o` and `Busy_o` are 0 after Ea.

## Test plan

- **Single request:** after reset, `Req_i`=0001 with D=5, timer cell instantiated in the bench.
  - `Grant_o`=0001 at E0.
  - `Timer_Preset_o` high one cycle with `Timer_PresetVal_o`=5.
  - `Timer_Enable_o` high 5 cycles.
  - `Done_o`=0001 at E7 for exactly one cycle; `Grant_o`=0 at E8.
- **D=0:** `Req_i`=0100 with D=0 → `Timer_Enable_o` never high; `Done_o`=0100 at E2.
- **Round-robin:** `Req_i`=1111 held continuously, each requester with D=3 and dropping its request one cycle after its done and re-raising it the next cycle → grant order 0,1,2,3,0; no gaps beyond one IDLE cycle between grants.
- **Abort:** requester 1 with D=100 drops `Req_i[1]` at RUN cycle 10, while requester 2 is pending.
  - No `Done_o[1]`.
  - `Timer_Enable_o` low from the next edge.
  - Requester 2 granted next, and its delay counts correctly from a fresh preset.
- **Reset mid-RUN:** `Reset_i` pulsed during RUN with D=50 → all outputs 0 after that edge; with `Req_i`=1010 afterwards, requester 1 is granted first (P=0).
